reg_cmd_sequencer: RTL and testbench
====================================

REG_CMD_SEQUENCER -- requirements
Module: reg_cmd_sequencer

Interface
REQ-001: Parameter NBits, default 16, data width of each controlled register.
REQ-002: Parameter NRegs, fixed at 4, number of controlled registers; index width 2.
REQ-003: The block SHALL have a single clock and a synchronous, active-high reset.
REQ-004: clock  in  1  sole clock; all state updates on rising edge.
REQ-005: reset  in  1  synchronous, active-high reset.
REQ-006: cmd_valid  in  1  command offered.
REQ-007: cmd_ready  out  1  sequencer can accept a command.
REQ-008: cmd_op  in  3  000 clear, 001 load, 010 decrement, 011 increment, 100 read; 101-111 illegal.
REQ-009: cmd_sel  in  2  target register index.
REQ-010: cmd_data  in  NBits  load value.
REQ-011: cmd_count  in  8  number of decrement/increment steps.
REQ-012: reg_funsel  out  2  funsel bus to all registers (00 clear, 01 load, 10 dec, 11 inc).
REQ-013: reg_en  out  NRegs  one-hot per-register enable; register acts on level (clear/load) or rising edge (dec/inc).
REQ-014: reg_i  out  NBits  shared load-data bus.
REQ-015: reg_q  in  NRegs*NBits  register outputs; register k at bits [k*NBits +: NBits].
REQ-016: rsp_valid  out  1  response available.
REQ-017: rsp_ready  in  1  response consumed.
REQ-018: rsp_data  out  NBits  target register value after the operation.
REQ-019: rsp_err  out  1  command carried an illegal opcode.
REQ-020: busy  out  1  high in every state except IDLE.

Function
REQ-021: States: IDLE, SETUP, PULSE, GAP, RESP; cmd_ready = 1 only in IDLE.
REQ-022: Accept on cmd_valid & cmd_ready; latch op, sel, data, count; go to SETUP.
REQ-023: SETUP: drive reg_funsel and reg_i from the latched command, reg_en = 0; this holds for exactly 1 cycle.
REQ-024: reg_funsel and reg_i SHALL stay constant from SETUP through the last GAP, so bus changes never coincide with reg_en high.
REQ-025: SETUP transitions: clear/load go to PULSE; dec/inc with count > 0 go to PULSE; dec/inc with count = 0, read, and illegal ops go directly to RESP.
REQ-026: PULSE: reg_en = 1 << sel for exactly 1 cycle, then GAP; GAP: reg_en = 0 for exactly 1 cycle.
REQ-027: After GAP: clear/load go to RESP; dec/inc decrement the remaining-step counter, returning to PULSE while it is nonzero, else going to RESP.
REQ-028: Dec/inc SHALL generate exactly count rising edges on the target enable (count = 1..255), with no glitch on other reg_en bits.
REQ-029: On entry to RESP, rsp_data SHALL capture reg_q slice[sel], and rsp_err = 1 for illegal ops, else 0.
REQ-030: RESP: rsp_valid = 1 and rsp_data/rsp_err are held stable until rsp_ready; on rsp_valid & rsp_ready, go to IDLE.
REQ-031: rsp_ready ignored outside RESP; cmd_valid ignored outside IDLE.
REQ-032: Latency from accept edge to rsp_valid high: read/illegal/count 0 = 2 cycles; clear/load = 4 cycles; dec/inc = 2 + 2*count cycles.
REQ-033: Register wrap-around on dec/inc is the register's own behaviour; the sequencer does not saturate or flag it.

Reset
REQ-034: Reset SHALL return the block to IDLE and zero reg_en, reg_funsel, reg_i, rsp_valid, rsp_data, rsp_err, busy, and the step counter.
REQ-035: cmd_ready is 0 while reset is asserted and 1 on the first cycle after deassertion.
REQ-036: Reset asserted mid-PULSE drops reg_en to 0 at that edge; the interrupted command SHALL produce no response.

Verification
REQ-037: Load: op 001, sel 2, data 0x1234 -> single reg_en = 0100 pulse with funsel 01 and reg_i 0x1234; rsp_data 0x1234 after 4 cycles.
REQ-038: Increment: op 011, sel 1, count 3, register preset 0xFFFE -> three reg_en = 0010 pulses separated by gap cycles; rsp_data 0x0001 after 8 cycles.
REQ-039: Read and illegal ops: op 100 sel 0 -> no reg_en activity, rsp_data = reg q0, rsp_err 0; op 111 -> no pulse, rsp_err 1.
REQ-040: Backpressure: hold rsp_ready 0 for 5 cycles -> rsp_valid, rsp_data and rsp_err stay stable, cmd_ready stays 0, and a new cmd_valid is not accepted.
REQ-041: Reset during the second PULSE of a count-4 decrement -> reg_en 0 at the next edge, no response, cmd_ready 1 after reset; the register has taken 2 decrements.

Source files
------------

// File: rtl/reg_cmd_sequencer.sv
// Command sequencer for a bank of four counter/load registers.
// It turns clear/load/dec/inc/read commands into guarded funsel/reg_i/reg_en sequences and returns the result.
module reg_cmd_sequencer #(
    parameter int NBits = 16,
    parameter int NRegs = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [2:0]             cmd_op,
    input  logic [1:0]             cmd_sel,
    input  logic [NBits-1:0]       cmd_data,
    input  logic [7:0]             cmd_count,
    output logic [1:0]             reg_funsel,
    output logic [NRegs-1:0]       reg_en,
    output logic [NBits-1:0]       reg_i,
    input  logic [NRegs*NBits-1:0] reg_q,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [NBits-1:0]       rsp_data,
    output logic                   rsp_err,
    output logic                   busy
);

    // state   | meaning
    // S_IDLE  | waiting for a command, cmd_ready high
    // S_SETUP | funsel/reg_i settle with all enables low
    // S_PULSE | one-cycle enable on the selected register
    // S_GAP   | enables low between pulses; step counter advances
    // S_RESP  | response held until rsp_ready
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_PULSE = 3'd2,
        S_GAP   = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    localparam logic [2:0] OP_CLEAR = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_DEC   = 3'b010;
    localparam logic [2:0] OP_INC   = 3'b011;
    localparam logic [2:0] OP_READ  = 3'b100;

    state_t            state;
    state_t            state_nxt;
    logic [2:0]        op_q;
    logic [1:0]        sel_q;
    logic [NBits-1:0]  data_q;
    logic [1:0]        funsel_q;
    logic [7:0]        cnt_q;
    logic [NRegs-1:0]  en_q;
    logic [NBits-1:0]  rsp_data_q;
    logic              rsp_err_q;

    logic [NBits-1:0]  q_slice [NRegs];
    logic [NRegs-1:0]  sel_onehot;
    logic              is_write;
    logic              is_step;
    logic              is_illegal;
    logic              accept;
    logic              enter_resp;

    always_comb begin
        for (int k = 0; k < NRegs; k++) begin
            q_slice[k] = reg_q[k*NBits +: NBits];
        end
    end

    always_comb begin
        sel_onehot        = '0;
        sel_onehot[sel_q] = 1'b1;
    end

    assign is_write   = (op_q == OP_CLEAR) || (op_q == OP_LOAD);
    assign is_step    = (op_q == OP_DEC) || (op_q == OP_INC);
    assign is_illegal = (op_q > OP_READ);

    assign cmd_ready  = (state == S_IDLE) && !reset;
    assign accept     = cmd_valid && cmd_ready;
    assign enter_resp = (state != S_RESP) && (state_nxt == S_RESP);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                if (is_write || (is_step && (cnt_q != 8'd0))) begin
                    state_nxt = S_PULSE;
                end else begin
                    state_nxt = S_RESP;
                end
            end
            S_PULSE: begin
                state_nxt = S_GAP;
            end
            S_GAP: begin
                // cnt_q still holds the steps including the pulse just finished
                if (is_step && (cnt_q != 8'd1)) begin
                    state_nxt = S_PULSE;
                end else begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            op_q       <= '0;
            sel_q      <= '0;
            data_q     <= '0;
            funsel_q   <= '0;
            cnt_q      <= '0;
            en_q       <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            en_q <= (state_nxt == S_PULSE) ? sel_onehot : '0;

            if (accept) begin
                op_q     <= cmd_op;
                sel_q    <= cmd_sel;
                data_q   <= cmd_data;
                cnt_q    <= cmd_count;
                funsel_q <= cmd_op[2] ? 2'b00 : cmd_op[1:0];
            end

            if ((state == S_GAP) && is_step) begin
                cnt_q <= cnt_q - 8'd1;
            end

            if (enter_resp) begin
                rsp_data_q <= q_slice[sel_q];
                rsp_err_q  <= is_illegal;
            end
        end
    end

    // Bus values come straight from flops loaded only at accept, so they cannot move under an enable.
    assign reg_funsel = funsel_q;
    assign reg_i      = data_q;
    assign reg_en     = en_q;
    assign rsp_valid  = (state == S_RESP);
    assign rsp_data   = rsp_data_q;
    assign rsp_err    = rsp_err_q;
    assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_reg_cmd_sequencer.sv
// Randomized bench for reg_cmd_sequencer: a behavioural register bank answers reg_en, and an
// arithmetic model predicts values, pulse counts, latency and error flags for every command.
module tb_reg_cmd_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = '0;
    logic [1:0]  cmd_sel = '0;
    logic [15:0] cmd_data = '0;
    logic [7:0]  cmd_count = '0;
    logic [1:0]  reg_funsel;
    logic [3:0]  reg_en;
    logic [15:0] reg_i;
    logic [63:0] reg_q;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] regs [4]       = '{default: 16'h0000};
    logic [15:0] model_regs [4] = '{default: 16'h0000};
    int          rise_cnt [4]   = '{default: 0};
    logic [3:0]  prev_en        = 4'b0000;
    logic [1:0]  last_funsel    = 2'b00;
    logic [15:0] last_regi      = 16'h0000;

    reg_cmd_sequencer #(.NBits(16), .NRegs(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_sel    (cmd_sel),
        .cmd_data   (cmd_data),
        .cmd_count  (cmd_count),
        .reg_funsel (reg_funsel),
        .reg_en     (reg_en),
        .reg_i      (reg_i),
        .reg_q      (reg_q),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    assign reg_q = {regs[3], regs[2], regs[1], regs[0]};

    // Register bank: acts once on each rising edge of its enable.
    always @(reg_en) begin
        for (int k = 0; k < 4; k++) begin
            if (reg_en[k] && !prev_en[k]) begin
                rise_cnt[k]++;
                last_funsel = reg_funsel;
                last_regi   = reg_i;
                case (reg_funsel)
                    2'b00:   regs[k] = 16'h0000;
                    2'b01:   regs[k] = reg_i;
                    2'b10:   regs[k] = regs[k] - 16'h0001;
                    default: regs[k] = regs[k] + 16'h0001;
                endcase
            end
        end
        prev_en = reg_en;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready();
        int waited = 0;
        while (!cmd_ready && waited < 50) begin
            @(negedge clock);
            waited++;
        end
        check_val("ready_before_cmd", {31'd0, cmd_ready}, 32'd1);
    endtask

    task automatic run_cmd(input logic [2:0] op, input logic [1:0] sel, input logic [15:0] data,
                           input logic [7:0] count, input int hold);
        logic [15:0] exp_val;
        logic [1:0]  exp_funsel;
        int          exp_pulses;
        int          exp_lat;
        int          lat;
        int          base [4];

        exp_val    = model_regs[sel];
        exp_funsel = op[1:0];
        exp_pulses = 0;
        exp_lat    = 2;
        case (op)
            3'd0: begin exp_val = 16'h0000; exp_pulses = 1; exp_lat = 4; end
            3'd1: begin exp_val = data;     exp_pulses = 1; exp_lat = 4; end
            3'd2: begin
                exp_val    = model_regs[sel] - {8'h00, count};
                exp_pulses = int'(count);
                exp_lat    = 2 + 2 * int'(count);
            end
            3'd3: begin
                exp_val    = model_regs[sel] + {8'h00, count};
                exp_pulses = int'(count);
                exp_lat    = 2 + 2 * int'(count);
            end
            default: ;
        endcase

        wait_ready();
        for (int k = 0; k < 4; k++) base[k] = rise_cnt[k];
        cmd_op    = op;
        cmd_sel   = sel;
        cmd_data  = data;
        cmd_count = count;
        cmd_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        lat = 1;
        // Garbage offered while busy must be ignored.
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_op    = 3'($urandom);
        cmd_sel   = 2'($urandom);
        cmd_data  = 16'($urandom);
        cmd_count = 8'($urandom);
        check_val("busy_after_accept", {30'd0, busy, cmd_ready}, 32'd2);

        while (!rsp_valid && lat < 600) begin
            @(negedge clock);
            lat++;
        end
        check_val("latency", lat, exp_lat);

        repeat (hold) @(negedge clock);
        check_val("rsp_held", {30'd0, rsp_valid, cmd_ready}, 32'd2);
        check_val("rsp_data", rsp_data, exp_val);
        check_val("rsp_err", rsp_err, (op > 3'd4) ? 32'd1 : 32'd0);
        for (int k = 0; k < 4; k++) begin
            check_val($sformatf("pulses_r%0d", k), rise_cnt[k] - base[k],
                      (k == int'(sel)) ? exp_pulses : 0);
        end
        if (exp_pulses > 0) begin
            check_val("bus_at_pulse", {14'd0, last_funsel, last_regi}, {14'd0, exp_funsel, data});
        end
        model_regs[sel] = exp_val;
        check_val("reg_value", regs[sel], exp_val);

        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        rsp_ready = 1'b0;
        check_val("rsp_done", {30'd0, rsp_valid, cmd_ready}, 32'd1);
    endtask

    task automatic reset_mid_pulse();
        int base3;
        int waited = 0;
        run_cmd(3'b001, 2'd3, 16'h0010, 8'd0, 0);
        wait_ready();
        base3     = rise_cnt[3];
        cmd_op    = 3'b010;
        cmd_sel   = 2'd3;
        cmd_count = 8'd4;
        cmd_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        cmd_valid = 1'b0;
        while ((rise_cnt[3] - base3) < 2 && waited < 40) begin
            @(negedge clock);
            waited++;
        end
        check_val("en_second_pulse", reg_en, 32'h8);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check_val("rst_en_dropped", reg_en, 32'h0);
        check_val("rst_idle", {29'd0, rsp_valid, busy, cmd_ready}, 32'd0);
        reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check_val("ready_after_rst", {31'd0, cmd_ready}, 32'd1);
        repeat (5) @(negedge clock);
        check_val("no_rsp_after_rst", {31'd0, rsp_valid}, 32'd0);
        check_val("rsp_cleared", {15'd0, rsp_err, rsp_data}, 32'd0);
        check_val("partial_decs", rise_cnt[3] - base3, 32'd2);
        model_regs[3] = model_regs[3] - 16'd2;
        check_val("reg_after_rst", regs[3], model_regs[3]);
    endtask

    initial begin
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_val("reset_ready", {31'd0, cmd_ready}, 32'd0);
        check_val("reset_outputs", {reg_en, reg_funsel, busy, rsp_valid, rsp_err}, 32'd0);
        check_val("reset_buses", {reg_i, rsp_data}, 32'd0);
        reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check_val("ready_after_init", {30'd0, cmd_ready, busy}, 32'd2);

        run_cmd(3'b001, 2'd2, 16'h1234, 8'd0, 0);
        run_cmd(3'b001, 2'd1, 16'hFFFE, 8'd0, 0);
        run_cmd(3'b011, 2'd1, 16'h0000, 8'd3, 0);
        run_cmd(3'b100, 2'd0, 16'h0000, 8'd0, 0);
        run_cmd(3'b111, 2'd2, 16'hBEEF, 8'd5, 0);
        run_cmd(3'b001, 2'd0, 16'hA5A5, 8'd0, 5);
        run_cmd(3'b010, 2'd0, 16'h0000, 8'd0, 2);
        run_cmd(3'b010, 2'd0, 16'h0000, 8'd1, 0);
        run_cmd(3'b000, 2'd2, 16'h7777, 8'd0, 1);
        run_cmd(3'b010, 2'd2, 16'h0000, 8'd2, 0);

        for (int i = 0; i < 40; i++) begin
            logic [7:0] cnt;
            cnt = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 6));
            run_cmd(3'($urandom_range(0, 7)), 2'($urandom), 16'($urandom), cnt, $urandom_range(0, 4));
        end

        reset_mid_pulse();
        run_cmd(3'b100, 2'd3, 16'h0000, 8'd0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
